// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4:1 round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping 3->0.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic             found;
    logic [SEL_W-1:0] cand;

    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_4x1.sv
// Four requesters share one registered output word through a round-robin granted 4:1 mux.
// Optional grant timeout after HOLD_MAX accepted words: define MUX_ARB_TIMEOUT_EN.
module mux_arb_4x1
    import mux_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [N-1:0]       data_a,
    input  logic [N-1:0]       data_b,
    input  logic [N-1:0]       data_c,
    input  logic [N-1:0]       data_d,
    output logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               y_valid,
    input  logic               y_ready,
    output logic [N-1:0]       y_data
);

    if (HOLD_MAX < 1) begin : g_bad_hold_max
        $error("mux_arb_4x1: HOLD_MAX must be at least 1");
    end

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               y_valid_q, y_valid_d;
    logic [N-1:0]       y_data_q, y_data_d;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic               load;
    logic               ack_sel;
    logic               hold_expired;
    logic               release_now;
    logic [N-1:0]       mux_word;

    rr_pick4 u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        case (sel_q)
            2'd0:    mux_word = data_a;
            2'd1:    mux_word = data_b;
            2'd2:    mux_word = data_c;
            default: mux_word = data_d;
        endcase
    end

    // The owner's word is consumed only when the output register can take it.
    assign load    = !y_valid_q || y_ready;
    assign ack_sel = (state_q == BUSY) && req[sel_q] && load;
    assign ack     = ack_sel ? idx_to_onehot(sel_q) : '0;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HC_W = $clog2(HOLD_MAX + 1);

    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

    // The HOLD_MAX-th ack is still consumed; the grant ends on that same edge.
    assign hold_expired = ack_sel && (hold_cnt_q == HC_W'(HOLD_MAX - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (release_now) begin
            hold_cnt_d = '0;
        end else if (ack_sel) begin
            hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    assign release_now = (state_q == BUSY) && (!req[sel_q] || hold_expired);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    gnt_d   = idx_to_onehot(pick_idx);
                    sel_d   = pick_idx;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    sel_d    = '0;
                    rr_ptr_d = sel_q + SEL_W'(1);
                end
            end
        endcase
    end

    // Output register runs independently of the grant FSM.
    always_comb begin
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        if (ack_sel) begin
            y_valid_d = 1'b1;
            y_data_d  = mux_word;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            rr_ptr_q  <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            rr_ptr_q  <= rr_ptr_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;

endmodule

// File: tb/tb_mux_arb_4x1.sv
// Randomized bench for mux_arb_4x1 with a transaction-level arbiter model and output scoreboard.
module tb_mux_arb_4x1;

    localparam int N        = 4;
    localparam int HOLD_MAX = 4;
    localparam int CYCLES   = 3000;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [N-1:0] data_a = '0;
    logic [N-1:0] data_b = '0;
    logic [N-1:0] data_c = '0;
    logic [N-1:0] data_d = '0;
    logic         y_ready = 1'b0;
    logic [3:0]   ack;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         y_valid;
    logic [N-1:0] y_data;

    always #5 clk = ~clk;

    mux_arb_4x1 #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_a  (data_a),
        .data_b  (data_b),
        .data_c  (data_c),
        .data_d  (data_d),
        .ack     (ack),
        .gnt     (gnt),
        .sel     (sel),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_data  (y_data)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    logic [N-1:0] exp_q[$];

    // Reference state: current owner (-1 when nobody holds the mux), next
    // round-robin start, words taken in this grant, and output-register occupancy.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_full  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] word_of(input int i);
        case (i)
            0:       return data_a;
            1:       return data_b;
            2:       return data_c;
            default: return data_d;
        endcase
    endfunction

    // Monitor: every word leaving the output stage must be the oldest accepted word.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL y_data_unexpected: got %0h, expected no word at %0t", y_data, $time);
                end else begin
                    chk("y_data", y_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0] e_ack;
        logic [3:0] e_gnt;
        logic [1:0] e_sel;
        bit         do_rst;
        bit         did_mid;
        bit         load;
        int         o;

        did_mid = 1'b0;
        req     = 4'hF;
        y_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_gnt", gnt, 0);
        chk("reset_sel", sel, 0);
        chk("reset_y_valid", y_valid, 0);
        chk("reset_y_data", y_data, 0);
        chk("reset_ack", ack, 0);

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            rst_n = 1'b1;

            if (cyc >= CYCLES - 20) begin
                req     = '0;
                y_ready = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(3) == 0) req[i] = ~req[i];
                end
                if ((cyc % 64) < 6) y_ready = 1'b0;
                else                y_ready = ($urandom_range(3) != 0);
            end
            data_a = N'($urandom);
            data_b = N'($urandom);
            data_c = N'($urandom);
            data_d = N'($urandom);

            do_rst = (cyc == 1500) || (!did_mid && cyc > 400 && m_owner == 3);
            if (do_rst) begin
                rst_n = 1'b0;
                #1;
                chk("midreset_gnt", gnt, 0);
                chk("midreset_sel", sel, 0);
                chk("midreset_y_valid", y_valid, 0);
                chk("midreset_y_data", y_data, 0);
                chk("midreset_ack", ack, 0);
                exp_q.delete();
                m_owner = -1;
                m_ptr   = 0;
                m_held  = 0;
                m_full  = 1'b0;
                did_mid = 1'b1;
                continue;
            end

            #1;
            e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            e_sel = (m_owner < 0) ? 2'd0 : 2'(m_owner);
            e_ack = 4'b0000;
            load  = !m_full || y_ready;
            chk("y_valid", y_valid, m_full);

            if (m_owner < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
                end
            end else begin
                o = m_owner;
                if (!req[o]) begin
                    m_owner = -1;
                    m_ptr   = (o + 1) % 4;
                    m_held  = 0;
                end else if (load) begin
                    e_ack = 4'(1 << o);
                    exp_q.push_back(word_of(o));
                    m_held++;
                    if (TIMEOUT_ON && m_held == HOLD_MAX) begin
                        m_owner = -1;
                        m_ptr   = (o + 1) % 4;
                        m_held  = 0;
                    end
                end
            end

            chk("ack", ack, e_ack);
            chk("gnt", gnt, e_gnt);
            chk("sel", sel, e_sel);
            if (e_ack != 0)   m_full = 1'b1;
            else if (y_ready) m_full = 1'b0;
        end

        @(negedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
